// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
//   Sequential truth-table sweeper for a small combinational block.
//   Steps stim through every input vector, holds each for SETTLE+1 cycles,
//   samples resp on the last edge of that window and compares it against
//   the packed expected table EXP_TT. Reports mismatch count, first failing
//   index and pass/fail on a start/done handshake.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            request a sweep (sampled only in IDLE)
//   abort            end a running sweep without done
//   resp             outputs of the block under check
//   stim             registered input vector to the block under check
//   busy             high while sweeping
//   done             one-cycle pulse at sweep end
//   pass             last completed sweep had zero mismatches
//   err_cnt          mismatch count, saturates at 2^N_IN
//   first_fail_valid at least one mismatch in the last sweep
//   first_fail_idx   stim index of the first mismatch
//
// state  | meaning
// IDLE   | waiting for start; previous results held
// RUN    | stepping vectors, sampling and comparing
// FINISH | one-cycle done pulse, pass valid

module tt_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXP_TT = 16'h848E
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] resp,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_cnt,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_idx
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]   SETTLE_LD = SW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX  = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ERR_MAX   = {1'b1, {N_IN{1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [SW-1:0]   settle_cnt;
  logic            sample;
  logic            mismatch;
  logic [N_OUT-1:0] exp_resp;
  logic [N_IN:0]   err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // sample is the edge on which resp is compared; abort suppresses it so
  // the aborted vector is never counted.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (settle_cnt == '0) begin
          sample = 1'b1;
          if (stim == LAST_IDX) state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign exp_resp = EXP_TT[int'(stim)*N_OUT +: N_OUT];
  assign mismatch = sample && (resp != exp_resp);
  assign err_next = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      settle_cnt       <= '0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            stim             <= '0;
            settle_cnt       <= SETTLE_LD;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            pass             <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            pass <= 1'b0;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else begin
            err_cnt <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= stim;
            end
            // pass uses err_next so the final vector's compare is included
            if (stim == LAST_IDX) begin
              pass <= (err_next == '0);
            end else begin
              stim       <= stim + 1'b1;
              settle_cnt <= SETTLE_LD;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b, abort;
  logic [2:0] stim_a, stim_b;
  logic [1:0] resp_a, resp_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] err_a, err_b;
  logic       ffv_a, ffv_b;
  logic [2:0] ffi_a, ffi_b;
  int         mode_a, mode_b;
  int         checks, failures;

  tt_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1), .EXP_TT(16'h848E)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .resp(resp_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail_valid(ffv_a), .first_fail_idx(ffi_a)
  );

  tt_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(0), .EXP_TT(16'h848E)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .resp(resp_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail_valid(ffv_b), .first_fail_idx(ffi_b)
  );

  // block under check: mode 0 correct, 1 e stuck at 0, 2 d inverted
  function automatic logic [1:0] fun_model(input logic [2:0] s, input int mode);
    logic a, b, c, d, e;
    a = s[2]; b = s[1]; c = s[0];
    d = ~(a | b) | (b & c);
    e = (b & c) ^ c;
    if (mode == 1) e = 1'b0;
    if (mode == 2) d = ~d;
    return {d, e};
  endfunction

  always_comb resp_a = fun_model(stim_a, mode_a);
  always_comb resp_b = fun_model(stim_b, mode_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (stim_a !== 3'd0) begin failures++; $display("FAIL reset stim_a got %0d want 0", stim_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
      failures++; $display("FAIL reset flags_a got busy=%b done=%b pass=%b want 000", busy_a, done_a, pass_a); end
    checks++; if (err_a !== 4'd0 || ffv_a !== 1'b0 || ffi_a !== 3'd0) begin
      failures++; $display("FAIL reset results_a got err=%0d ffv=%b ffi=%0d want 0 0 0", err_a, ffv_a, ffi_a); end
    checks++; if (stim_b !== 3'd0 || busy_b !== 1'b0 || done_b !== 1'b0 || err_b !== 4'd0) begin
      failures++; $display("FAIL reset b got stim=%0d busy=%b done=%b err=%0d want 0", stim_b, busy_b, done_b, err_b); end
  endtask

  task automatic test_pass_sweep();
    mode_a = 0; start_a = 1'b1; tick(); start_a = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c <= 16) begin
        checks++; if (stim_a !== 3'((c - 1) / 2)) begin
          failures++; $display("FAIL pass_sweep stim cycle %0d got %0d want %0d", c, stim_a, (c - 1) / 2); end
        checks++; if (busy_a !== 1'b1) begin
          failures++; $display("FAIL pass_sweep busy cycle %0d got %b want 1", c, busy_a); end
      end
      checks++; if (done_a !== (c == 17)) begin
        failures++; $display("FAIL pass_sweep done cycle %0d got %b want %b", c, done_a, (c == 17)); end
      if (c < 17) tick();
    end
    checks++; if (pass_a !== 1'b1 || err_a !== 4'd0 || ffv_a !== 1'b0) begin
      failures++; $display("FAIL pass_sweep result got pass=%b err=%0d ffv=%b want 1 0 0", pass_a, err_a, ffv_a); end
    checks++; if (stim_a !== 3'd7) begin failures++; $display("FAIL pass_sweep stim_end got %0d want 7", stim_a); end
    tick();
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0 || pass_a !== 1'b1 || stim_a !== 3'd7) begin
      failures++; $display("FAIL pass_sweep idle got done=%b busy=%b pass=%b stim=%0d want 0 0 1 7",
                           done_a, busy_a, pass_a, stim_a); end
  endtask

  task automatic test_stuck_e();
    mode_a = 1; start_a = 1'b1; tick(); start_a = 1'b0;
    for (int c = 1; c < 17; c++) tick();
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL stuck_e done got %b want 1", done_a); end
    checks++; if (err_a !== 4'd2) begin failures++; $display("FAIL stuck_e err_cnt got %0d want 2", err_a); end
    checks++; if (ffv_a !== 1'b1 || ffi_a !== 3'd1) begin
      failures++; $display("FAIL stuck_e first_fail got valid=%b idx=%0d want 1 1", ffv_a, ffi_a); end
    checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL stuck_e pass got %b want 0", pass_a); end
    tick();
  endtask

  task automatic test_settle0();
    mode_b = 0; start_b = 1'b1; tick(); start_b = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) begin
        checks++; if (stim_b !== 3'(c - 1)) begin
          failures++; $display("FAIL settle0 stim cycle %0d got %0d want %0d", c, stim_b, c - 1); end
      end
      checks++; if (done_b !== (c == 9)) begin
        failures++; $display("FAIL settle0 done cycle %0d got %b want %b", c, done_b, (c == 9)); end
      if (c < 9) tick();
    end
    checks++; if (pass_b !== 1'b1 || err_b !== 4'd0) begin
      failures++; $display("FAIL settle0 result got pass=%b err=%0d want 1 0", pass_b, err_b); end
    tick();
    mode_b = 2; start_b = 1'b1; tick(); start_b = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL settle0_inv done got %b want 1", done_b); end
    checks++; if (err_b !== 4'd8) begin failures++; $display("FAIL settle0_inv err_cnt got %0d want 8", err_b); end
    checks++; if (ffv_b !== 1'b1 || ffi_b !== 3'd0 || pass_b !== 1'b0) begin
      failures++; $display("FAIL settle0_inv result got ffv=%b ffi=%0d pass=%b want 1 0 0", ffv_b, ffi_b, pass_b); end
    tick();
  endtask

  task automatic test_start_ignored();
    int dones;
    dones = 0;
    checks++; if (err_a !== 4'd2 || pass_a !== 1'b0) begin
      failures++; $display("FAIL start_ign held got err=%0d pass=%b want 2 0", err_a, pass_a); end
    mode_a = 0; start_a = 1'b1; tick(); start_a = 1'b0;
    checks++; if (err_a !== 4'd0 || ffv_a !== 1'b0 || ffi_a !== 3'd0) begin
      failures++; $display("FAIL start_ign cleared got err=%0d ffv=%b ffi=%0d want 0 0 0", err_a, ffv_a, ffi_a); end
    for (int c = 1; c <= 20; c++) begin
      start_a = (c == 3 || c == 16);
      if (done_a === 1'b1) dones++;
      if (c == 17) begin
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL start_ign done17 got %b want 1", done_a); end
      end
      tick();
      start_a = 1'b0;
    end
    checks++; if (dones != 1) begin failures++; $display("FAIL start_ign done_count got %0d want 1", dones); end
    checks++; if (busy_a !== 1'b0 || pass_a !== 1'b1) begin
      failures++; $display("FAIL start_ign end got busy=%b pass=%b want 0 1", busy_a, pass_a); end
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    mode_a = 1; start_a = 1'b1; tick(); start_a = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
      failures++; $display("FAIL abort state got busy=%b done=%b pass=%b want 0 0 0", busy_a, done_a, pass_a); end
    checks++; if (err_a !== 4'd1 || ffv_a !== 1'b1 || ffi_a !== 3'd1) begin
      failures++; $display("FAIL abort partial got err=%0d ffv=%b ffi=%0d want 1 1 1", err_a, ffv_a, ffi_a); end
    for (int c = 0; c < 20; c++) begin
      if (done_a === 1'b1) dones++;
      tick();
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL abort no_done got %0d want 0", dones); end
    // start wins over abort in IDLE; abort in FINISH is ignored
    mode_a = 0; start_a = 1'b1; abort = 1'b1; tick(); start_a = 1'b0; abort = 1'b0;
    checks++; if (busy_a !== 1'b1 || stim_a !== 3'd0) begin
      failures++; $display("FAIL abort start_wins got busy=%b stim=%0d want 1 0", busy_a, stim_a); end
    for (int c = 1; c < 17; c++) tick();
    abort = 1'b1;
    checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL abort finish_done got %b want 1", done_a); end
    tick(); abort = 1'b0;
    checks++; if (pass_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++; $display("FAIL abort finish_after got pass=%b busy=%b done=%b want 1 0 0", pass_a, busy_a, done_a); end
  endtask

  task automatic test_reset_mid();
    mode_a = 1; start_a = 1'b1; tick(); start_a = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    checks++; if (stim_a !== 3'd4 || err_a !== 4'd1) begin
      failures++; $display("FAIL reset_mid pre got stim=%0d err=%0d want 4 1", stim_a, err_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stim_a !== 3'd0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
      failures++; $display("FAIL reset_mid flags got stim=%0d busy=%b done=%b pass=%b want 0", stim_a, busy_a, done_a, pass_a); end
    checks++; if (err_a !== 4'd0 || ffv_a !== 1'b0 || ffi_a !== 3'd0) begin
      failures++; $display("FAIL reset_mid results got err=%0d ffv=%b ffi=%0d want 0", err_a, ffv_a, ffi_a); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL reset_mid idle got done=%b busy=%b want 0 0", done_a, busy_a); end
    mode_a = 0; start_a = 1'b1; tick(); start_a = 1'b0;
    for (int c = 1; c < 17; c++) tick();
    checks++; if (done_a !== 1'b1 || pass_a !== 1'b1 || err_a !== 4'd0) begin
      failures++; $display("FAIL reset_mid resweep got done=%b pass=%b err=%0d want 1 1 0", done_a, pass_a, err_a); end
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    mode_a = 0; mode_b = 0;
    #7;
    test_reset();
    #1 rst_n = 1'b1;
    tick();
    test_pass_sweep();
    test_stuck_e();
    test_settle0();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
